// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FASTMUL_EN to make MULT/MULTU finish in one cycle through a combinational multiplier.
module muldiv_sequencer (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic [2:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iRead,
  output logic [31:0] oHI,
  output logic [31:0] oLO,
  output logic        oBusy,
  output logic        oDone,
  output logic        oStall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op, a_neg, b_neg, launch;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] product;

  assign signed_op = (iOp == OP_MULT) || (iOp == OP_DIV);
  assign a_neg     = signed_op & iA[31];
  assign b_neg     = signed_op & iB[31];
  assign a_mag     = a_neg ? (32'd0 - iA) : iA;
  assign b_mag     = b_neg ? (32'd0 - iB) : iB;

  // One multiply step: conditionally add multiplicand into HI, then shift {HI,LO} right.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
  // One restoring divide step: remainder stays below the divisor, so 32-bit difference suffices.
  assign div_shift = {acc_hi_q, acc_lo_q[31]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[31:0] - opb_q;
  assign product   = {acc_hi_q, acc_lo_q};

`ifdef MULDIV_FASTMUL_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{32{a_neg}}, iA};
  assign ext_b     = {{32{b_neg}}, iB};
  assign fast_prod = ext_a * ext_b;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    launch    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          case (iOp)
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FASTMUL_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              launch = 1'b1;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (iB == 32'd0) begin
                hi_d   = iA;
                lo_d   = 32'hFFFF_FFFF;
                done_d = 1'b1;
              end else begin
                launch = 1'b1;
              end
            end
            OP_MTHI: hi_d = iA;
            OP_MTLO: lo_d = iA;
            default: ;
          endcase
        end
        if (launch) begin
          state_d   = S_CALC;
          cnt_d     = 6'd0;
          acc_hi_d  = 32'd0;
          acc_lo_d  = a_mag;
          opb_d     = b_mag;
          is_div_d  = iOp[1];
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
        end
      end
      S_CALC: begin
        if (cnt_q == 6'd32) begin
          state_d = S_SIGN;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (is_div_q) begin
            acc_hi_d = div_ge ? div_diff : div_shift[31:0];
            acc_lo_d = {acc_lo_q[30:0], div_ge};
          end else begin
            acc_hi_d = mul_sum[32:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
          end
        end
      end
      S_SIGN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = neg_q ? (32'd0 - acc_lo_q) : acc_lo_q;
          hi_d = neg_rem_q ? (32'd0 - acc_hi_q) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_q ? (64'd0 - product) : product;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opb_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign oHI    = hi_q;
  assign oLO    = lo_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oDone  = done_q;
  assign oStall = (iRead | iStart) & oBusy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops against an arithmetic model.
module tb_muldiv_sequencer;

  logic        iCLK = 1'b0;
  logic        iRST, iStart, iRead;
  logic [2:0]  iOp;
  logic [31:0] iA, iB;
  logic [31:0] oHI, oLO;
  logic        oBusy, oDone, oStall;

  muldiv_sequencer dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .iRead(iRead), .oHI(oHI), .oLO(oLO), .oBusy(oBusy), .oDone(oDone), .oStall(oStall)
  );

  always #5 iCLK = ~iCLK;

`ifdef MULDIV_FASTMUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  // Architectural result of one request, from plain integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl,
                       output int lat, output logic dn);
    longint sa, sb, sq, sr;
    logic [63:0] p, tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nh = exp_hi; nl = exp_lo; lat = 0; dn = 1'b0;
    case (op)
      3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; lat = MUL_LAT; dn = 1'b1; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; nh = p[63:32]; nl = p[31:0]; lat = MUL_LAT; dn = 1'b1; end
      3'd2, 3'd3: begin
        dn = 1'b1;
        if (b == 32'd0) begin
          nh = a; nl = 32'hFFFF_FFFF; lat = 1;
        end else begin
          lat = 34;
          if (op == 3'd2) begin sq = sa / sb; sr = sa % sb; tq = sq; tr = sr; end
          else begin tq = {32'd0, a / b}; tr = {32'd0, a % b}; end
          nl = tq[31:0]; nh = tr[31:0];
        end
      end
      3'd4: begin nh = a; lat = 1; end
      3'd5: begin nl = a; lat = 1; end
      default: lat = 0;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int lat;
    logic dn, bad;
    model(op, a, b, nh, nl, lat, dn);
    iOp = op; iA = a; iB = b; iStart = 1'b1;
    tick;
    iStart = 1'b0; iA = $urandom; iB = $urandom;
    if (lat == 34) begin
      n_cmp++;
      if (oBusy !== 1'b1 || oDone !== 1'b0) begin
        n_bad++; $display("FAIL %s busy_rise: busy=%b done=%b want busy=1 done=0", name, oBusy, oDone);
      end
      bad = 1'b0;
      repeat (33) begin
        tick;
        if (oDone !== 1'b0 || oBusy !== 1'b1 || oHI !== exp_hi || oLO !== exp_lo) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
        n_bad++; $display("FAIL %s hold: outputs changed during calc, hi=%h lo=%h want %h %h", name, oHI, oLO, exp_hi, exp_lo);
      end
      tick;
    end
    n_cmp++;
    if (oHI !== nh || oLO !== nl) begin
      n_bad++; $display("FAIL %s result: hi=%h lo=%h want hi=%h lo=%h", name, oHI, oLO, nh, nl);
    end
    n_cmp++;
    if (oDone !== dn || oBusy !== 1'b0) begin
      n_bad++; $display("FAIL %s done: done=%b busy=%b want done=%b busy=0", name, oDone, oBusy, dn);
    end
    $display("op=%0d a=%h b=%h lat=%0d -> hi=%h lo=%h (%s)", op, a, b, lat, oHI, oLO, name);
    exp_hi = nh; exp_lo = nl;
    tick;
    n_cmp++;
    if (oDone !== 1'b0) begin
      n_bad++; $display("FAIL %s done_pulse: done=%b want 0", name, oDone);
    end
  endtask

  task automatic test_reset;
    iRST = 1'b1; iStart = 1'b0; iRead = 1'b0; iOp = 3'd0; iA = 32'd0; iB = 32'd0;
    tick; tick;
    n_cmp++;
    if (oHI !== 32'd0 || oLO !== 32'd0 || oBusy !== 1'b0 || oDone !== 1'b0 || oStall !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b want all 0", oHI, oLO, oBusy, oDone, oStall);
    end
    iRST = 1'b0; iRead = 1'b1;
    #1;
    n_cmp++;
    if (oStall !== 1'b0) begin
      n_bad++; $display("FAIL idle_read_stall: stall=%b want 0", oStall);
    end
    iRead = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    $display("reset applied");
  endtask

  task automatic test_directed;
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by_zero", 3'd3, 32'h0000_1234, 32'd0);
    run_op("div_by_zero", 3'd2, 32'hDEAD_BEEF, 32'd0);
    run_op("multu_6x7", 3'd1, 32'd6, 32'd7);
    run_op("mthi", 3'd4, 32'h1357_9BDF, 32'd0);
    run_op("mtlo", 3'd5, 32'h2468_ACE0, 32'd0);
    run_op("reserved6", 3'd6, 32'h1111_1111, 32'h2222_2222);
    run_op("reserved7", 3'd7, 32'h3333_3333, 32'h4444_4444);
  endtask

  task automatic test_stall;
    logic bad;
    iOp = 3'd0; iA = 32'd3; iB = 32'hFFFF_FFFB; iStart = 1'b1;
    tick;
    iOp = 3'd4; iA = 32'hCAFE_F00D; iB = 32'd0; iRead = 1'b1;
    n_cmp++;
    if (oStall !== 1'b1) begin
      n_bad++; $display("FAIL stall_raise: stall=%b want 1", oStall);
    end
    bad = 1'b0;
    repeat (MUL_LAT - 1) begin
      tick;
      if (oStall !== 1'b1 || oHI !== exp_hi || oLO !== exp_lo) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL stall_hold: stall dropped or HI/LO changed, hi=%h lo=%h want %h %h", oHI, oLO, exp_hi, exp_lo);
    end
    if (MUL_LAT > 1) tick;
    n_cmp++;
    if (oHI !== 32'hFFFF_FFFF || oLO !== 32'hFFFF_FFF1 || oDone !== 1'b1 || oStall !== 1'b0) begin
      n_bad++; $display("FAIL stall_mult: hi=%h lo=%h done=%b stall=%b want ffffffff fffffff1 1 0", oHI, oLO, oDone, oStall);
    end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
    tick;
    n_cmp++;
    if (oHI !== 32'hCAFE_F00D || oLO !== exp_lo || oDone !== 1'b0 || oBusy !== 1'b0) begin
      n_bad++; $display("FAIL stall_mthi: hi=%h lo=%h done=%b busy=%b want cafef00d %h 0 0", oHI, oLO, oDone, oBusy, exp_lo);
    end
    $display("mult 3x-5 with pending mthi -> hi=%h lo=%h", oHI, oLO);
    exp_hi = 32'hCAFE_F00D;
    iStart = 1'b0; iRead = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic bad;
    iOp = 3'd3; iA = 32'd100; iB = 32'd7; iStart = 1'b1;
    tick;
    iStart = 1'b0;
    repeat (9) tick;
    iRST = 1'b1;
    tick;
    iRST = 1'b0;
    n_cmp++;
    if (oHI !== 32'd0 || oLO !== 32'd0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_bad++; $display("FAIL abort_state: hi=%h lo=%h busy=%b done=%b want 0 0 0 0", oHI, oLO, oBusy, oDone);
    end
    exp_hi = 32'd0; exp_lo = 32'd0;
    bad = 1'b0;
    repeat (40) begin
      tick;
      if (oDone !== 1'b0 || oBusy !== 1'b0 || oHI !== 32'd0 || oLO !== 32'd0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++; $display("FAIL abort_quiet: aborted divide left an effect, hi=%h lo=%h", oHI, oLO);
    end
    $display("divu 100/7 aborted by reset");
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7);
    run_op("mtlo_before_rst", 3'd5, 32'h0000_0055, 32'd0);
    iRST = 1'b1; iStart = 1'b1; iOp = 3'd1; iA = 32'd3; iB = 32'd3;
    tick;
    iRST = 1'b0; iStart = 1'b0;
    tick;
    n_cmp++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oLO !== 32'd0 || oHI !== 32'd0) begin
      n_bad++; $display("FAIL rst_over_start: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", oBusy, oDone, oHI, oLO);
    end
    $display("reset with simultaneous start");
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] nh, nl, a1, b1, a2, b2;
    int lat;
    logic dn, bad;
    a1 = $urandom; b1 = $urandom_range(1, 1000);
    a2 = $urandom; b2 = $urandom | 32'd1;
    model(3'd3, a1, b1, nh, nl, lat, dn);
    iOp = 3'd3; iA = a1; iB = b1; iStart = 1'b1;
    tick;
    iA = a2; iB = b2;
    bad = 1'b0;
    repeat (33) begin
      tick;
      if (oStall !== 1'b1 || oDone !== 1'b0) bad = 1'b1;
    end
    tick;
    n_cmp++;
    if (bad || oHI !== nh || oLO !== nl || oDone !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: hi=%h lo=%h done=%b want hi=%h lo=%h done=1", oHI, oLO, oDone, nh, nl);
    end
    $display("op=3 a=%h b=%h -> hi=%h lo=%h (b2b first)", a1, b1, oHI, oLO);
    exp_hi = nh; exp_lo = nl;
    model(3'd3, a2, b2, nh, nl, lat, dn);
    tick;
    iStart = 1'b0;
    n_cmp++;
    if (oBusy !== 1'b1 || oDone !== 1'b0) begin
      n_bad++; $display("FAIL b2b_accept: busy=%b done=%b want 1 0", oBusy, oDone);
    end
    repeat (34) tick;
    n_cmp++;
    if (oHI !== nh || oLO !== nl || oDone !== 1'b1 || oBusy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second: hi=%h lo=%h done=%b want hi=%h lo=%h done=1", oHI, oLO, oDone, nh, nl);
    end
    $display("op=3 a=%h b=%h -> hi=%h lo=%h (b2b second)", a2, b2, oHI, oLO);
    exp_hi = nh; exp_lo = nl;
    tick;
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("random", op, a, b);
    end
  endtask

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    test_reset;
    test_directed;
    test_stall;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
